snax_gemm_csr_sequencer: RTL
============================

SNAX_GEMM_CSR_SEQUENCER -- requirements
Module: snax_gemm_csr_sequencer

Interface
REQ-001 SHALL have parameter NumRegs, default 16: number of configuration shadow registers, written to CSR addresses 0..NumRegs-1.
REQ-002 SHALL have parameter StartAddr, default 16: CSR address of the streamer/GEMM start register.
REQ-003 SHALL have parameter StatusAddr, default 17: CSR address of the busy-status register; bit 0 = busy.
REQ-004 SHALL have parameter PollGap, default 4, minimum 1: idle cycles between status polls.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port cfg_we_i, input, 1 bit: shadow-register write strobe.
REQ-008 SHALL have port cfg_idx_i, input, $clog2(NumRegs) bits: shadow-register index.
REQ-009 SHALL have port cfg_data_i, input, 32 bits: shadow-register write data.
REQ-010 SHALL have port launch_i, input, 1 bit: start-sequence request.
REQ-011 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port cycles_o, output, 32 bits: cycle count from the last launch to its done.
REQ-014 SHALL have ports csr_req_data_o (32), csr_req_addr_o (32), csr_req_write_o (1), csr_req_valid_o (1) as outputs, and csr_req_ready_i (1) as input: CSR request channel.
REQ-015 SHALL have ports csr_rsp_valid_i (1) and csr_rsp_data_i (32) as inputs, and csr_rsp_ready_o (1) as output: CSR read-response channel.

Function
REQ-016 SHALL implement FSM states IDLE, WR_CFG, WR_START, POLL_REQ, POLL_RSP, GAP, DONE.
REQ-017 SHALL write shadow register cfg_idx_i with cfg_data_i on cfg_we_i only in IDLE; writes in any other state are dropped.
REQ-018 SHALL treat launch_i as follows: IDLE->WR_CFG with idx=0 and cycle counter cleared; launch_i in any other state is ignored.
REQ-019 SHALL, in WR_CFG, drive valid=1, write=1, addr=idx, data=shadow[idx]; on valid&ready increment idx, and after idx NumRegs-1 go to WR_START.
REQ-020 SHALL, in WR_START, drive valid=1, write=1, addr=StartAddr, data=1; on handshake go to POLL_REQ.
REQ-021 SHALL, in POLL_REQ, drive valid=1, write=0, addr=StatusAddr, data=0; on handshake go to POLL_RSP.
REQ-022 SHALL, in POLL_RSP, drive csr_rsp_ready_o=1; on csr_rsp_valid_i go to DONE if csr_rsp_data_i[0]==0, else go to GAP.
REQ-023 SHALL hold GAP for exactly PollGap cycles, then go to POLL_REQ.
REQ-024 SHALL assert done_o for exactly one cycle in DONE, latch cycles_o, then return to IDLE.
REQ-025 SHALL keep request address, data and write stable while valid is high and ready is low; valid never drops before handshake.
REQ-026 SHALL drive csr_req_valid_o=0 in IDLE, POLL_RSP, GAP and DONE; all request fields are 0 when valid is 0.
REQ-027 SHALL drive csr_rsp_ready_o=0 outside POLL_RSP; csr_rsp_valid_i outside POLL_RSP is ignored (writes produce no response).
REQ-028 SHALL increment the cycle counter every cycle from WR_CFG entry through DONE, saturating at 2^32-1.
REQ-029 SHALL issue a request in the cycle of state entry (zero added latency); minimum total sequence = NumRegs+1 writes + 1 read + response + DONE cycle.

Reset
REQ-030 SHALL, on rst_ni low at any time including mid-sequence, immediately force state IDLE, idx 0, all shadow registers 0, counter 0, cycles_o 0, done_o 0, busy_o 0, csr_req_valid_o 0, csr_rsp_ready_o 0.

Verification
REQ-031 Full handshake: NumRegs=16, ready always 1, shadow[i]=0x100+i, status read returns 0 -> writes addr 0..15 data 0x100..0x10F, write 16<-1, one read of 17, done_o pulse, cycles_o=19.
REQ-032 Backpressure: ready low for 3 cycles on the idx 5 write -> addr 5 / data 0x105 held stable 4 cycles, no skip or duplicate.
REQ-033 Polling: status returns 1, 1, then 0 -> exactly 3 reads, each separated by PollGap=4 idle cycles, then done_o.
REQ-034 Ignored inputs: launch_i and cfg_we_i (idx 2 = 0xDEAD) mid-sequence -> no restart, shadow[2] unchanged, stray rsp_valid during WR_CFG ignored.
REQ-035 Reset mid-operation: rst_ni low during POLL_REQ -> valid=0, busy_o=0 asynchronously; next launch writes all-zero configuration.

Source files
------------

// File: rtl/snax_gemm_csr_sequencer.sv
// snax_gemm_csr_sequencer: replays shadow CSR config, starts the GEMM, polls busy and reports duration.
// Ports: clk_i/rst_ni clock and async active-low reset; cfg_we_i/cfg_idx_i/cfg_data_i shadow writes;
// launch_i starts a sequence; busy_o/done_o/cycles_o status; csr_req_* request channel;
// csr_rsp_* read-response channel.
module snax_gemm_csr_sequencer #(
  parameter int NumRegs    = 16,
  parameter int StartAddr  = 16,
  parameter int StatusAddr = 17,
  parameter int PollGap    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_we_i,
  input  logic [$clog2(NumRegs)-1:0] cfg_idx_i,
  input  logic [31:0]                cfg_data_i,
  input  logic                       launch_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [31:0]                cycles_o,
  output logic [31:0]                csr_req_data_o,
  output logic [31:0]                csr_req_addr_o,
  output logic                       csr_req_write_o,
  output logic                       csr_req_valid_o,
  input  logic                       csr_req_ready_i,
  input  logic                       csr_rsp_valid_i,
  input  logic [31:0]                csr_rsp_data_i,
  output logic                       csr_rsp_ready_o
);
  localparam int IW = $clog2(NumRegs);
  typedef enum logic [2:0] {IDLE, WR_CFG, WR_START, POLL_REQ, POLL_RSP, GAP, DONE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [31:0] shadow [NumRegs];
  logic [31:0] cnt, cnt_inc, gap;
  logic hs, unused_rsp;
  assign hs = csr_req_valid_o & csr_req_ready_i;
  assign cnt_inc = &cnt ? cnt : cnt + 32'd1;
  assign busy_o = state != IDLE;
  assign csr_rsp_ready_o = state == POLL_RSP;
  assign unused_rsp = ^csr_rsp_data_i[31:1];
  // Request fields decode straight from the state register, so they are stable until the handshake
  // and the request appears in the same cycle the state is entered.
  always_comb begin
    csr_req_valid_o = state inside {WR_CFG, WR_START, POLL_REQ};
    csr_req_write_o = state inside {WR_CFG, WR_START};
    csr_req_addr_o  = state == WR_CFG ? 32'(idx) : state == WR_START ? 32'(StartAddr) :
                      state == POLL_REQ ? 32'(StatusAddr) : 32'd0;
    csr_req_data_o  = state == WR_CFG ? shadow[idx] : state == WR_START ? 32'd1 : 32'd0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      gap      <= '0;
      cycles_o <= '0;
      done_o   <= 1'b0;
      for (int i = 0; i < NumRegs; i++) shadow[i] <= '0;
    end else begin
      done_o <= 1'b0;
      if (state != IDLE) cnt <= cnt_inc;
      case (state)
        IDLE: begin
          if (cfg_we_i) shadow[cfg_idx_i] <= cfg_data_i;
          if (launch_i) begin
            state <= WR_CFG;
            idx   <= '0;
            cnt   <= '0;
          end
        end
        WR_CFG: if (hs) begin
          idx <= idx == IW'(NumRegs - 1) ? '0 : idx + 1'b1;
          if (idx == IW'(NumRegs - 1)) state <= WR_START;
        end
        WR_START: if (hs) state <= POLL_REQ;
        POLL_REQ: if (hs) state <= POLL_RSP;
        POLL_RSP: if (csr_rsp_valid_i) begin
          gap    <= '0;
          state  <= csr_rsp_data_i[0] ? GAP : DONE;
          done_o <= !csr_rsp_data_i[0];
          // cycles_o is captured on entry to DONE so it is valid alongside the done pulse;
          // it counts every cycle from WR_CFG entry up to (not including) DONE.
          if (!csr_rsp_data_i[0]) cycles_o <= cnt_inc;
        end
        GAP: begin
          gap <= gap + 32'd1;
          if (gap == 32'(PollGap - 1)) state <= POLL_REQ;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
